// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data access.
// IDLE/ACCESS/RESP sequencing; data has priority, IF is forced after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int WCW = (WAIT_CYCLES  > 1) ? $clog2(WAIT_CYCLES)    : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WAIT_CYCLES - 1);
  localparam logic [SCW-1:0] S_MAX  = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t         r_state;
  logic [WCW-1:0] r_wcnt;
  logic [SCW-1:0] r_starve;
  logic           r_own_d;
  logic           w_grant_if;

  // IF wins only when alone or when data has starved it long enough
  assign w_grant_if = if_req && (!d_req || (r_starve == S_MAX));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_starve  <= '0;
      r_own_d   <= 1'b0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_req || d_req) begin
            r_state <= S_ACCESS;
            r_wcnt  <= '0;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            if (w_grant_if) begin
              if_gnt    <= 1'b1;
              r_own_d   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              r_starve  <= '0;
            end else begin
              d_gnt     <= 1'b1;
              r_own_d   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req && (r_starve != S_MAX)) r_starve <= r_starve + 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (r_wcnt == W_LAST) begin
            r_state <= S_RESP;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (r_own_d) begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;
  logic        CLK, RST;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [5:0] pattern;
    logic       seen;
    int         k;
    RST = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    RST = 1'b0;
    tick();

    // 1: lone fetch
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_if_gnt_c1", if_gnt, 1);
    chk("t1_d_gnt_c1", d_gnt, 0);
    chk("t1_mem_en_c1", mem_en, 1);
    chk("t1_mem_addr_c1", mem_addr, 32'h40);
    chk("t1_mem_we_c1", mem_we, 0);
    chk("t1_busy_c1", busy, 1);
    tick();
    chk("t1_if_gnt_c2", if_gnt, 0);
    chk("t1_mem_en_c2", mem_en, 1);
    tick();
    chk("t1_if_done_c3", if_done, 1);
    chk("t1_if_rdata_c3", if_rdata, 32'hDEADBEEF);
    chk("t1_mem_en_c3", mem_en, 0);
    if_req = 0;
    tick();
    chk("t1_if_done_c4", if_done, 0);
    chk("t1_busy_c4", busy, 0);

    // 2: contention, data first
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h80;
    mem_rdata = 32'h11111111;
    tick();
    chk("t2_d_gnt_c1", d_gnt, 1);
    chk("t2_if_gnt_c1", if_gnt, 0);
    chk("t2_mem_addr_c1", mem_addr, 32'h80);
    mem_rdata = 32'hAAAA5555;
    tick();
    tick();
    chk("t2_d_done_c3", d_done, 1);
    chk("t2_if_done_c3", if_done, 0);
    chk("t2_d_rdata_c3", d_rdata, 32'hAAAA5555);
    d_req = 0;
    tick();
    chk("t2_busy_c4", busy, 0);
    tick();
    chk("t2_if_gnt_c5", if_gnt, 1);
    chk("t2_mem_addr_c5", mem_addr, 32'h44);
    mem_rdata = 32'hCAFEF00D;
    tick();
    tick();
    chk("t2_if_done_c7", if_done, 1);
    chk("t2_if_rdata_c7", if_rdata, 32'hCAFEF00D);
    if_req = 0;
    tick();

    // 3: data write; later addr/data changes must be ignored
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
    tick();
    chk("t3_d_gnt_c1", d_gnt, 1);
    chk("t3_mem_we_c1", mem_we, 1);
    chk("t3_mem_addr_c1", mem_addr, 32'h100);
    chk("t3_mem_wdata_c1", mem_wdata, 32'h12345678);
    d_addr = 32'h999; d_wdata = 32'h0; mem_rdata = 32'hBAD0BAD0;
    tick();
    chk("t3_mem_we_c2", mem_we, 1);
    chk("t3_mem_addr_c2", mem_addr, 32'h100);
    chk("t3_mem_wdata_c2", mem_wdata, 32'h12345678);
    tick();
    chk("t3_d_done_c3", d_done, 1);
    chk("t3_d_rdata_kept", d_rdata, 32'hAAAA5555);
    chk("t3_mem_we_c3", mem_we, 0);
    d_req = 0; d_we = 0;
    tick();

    // 4: anti-starvation; bit g set = data grant expected
    pattern = 6'b101111;
    d_req = 1; d_we = 0; d_addr = 32'h200; if_req = 1; if_addr = 32'h48;
    for (int g = 0; g < 6; g++) begin
      k = 0;
      while (!(if_gnt || d_gnt) && k < 10) begin
        tick();
        k++;
      end
      chk($sformatf("t4_gnt%0d_seen", g), (k < 10), 1);
      chk($sformatf("t4_gnt%0d_data", g), d_gnt, pattern[g]);
      chk($sformatf("t4_gnt%0d_if", g), if_gnt, !pattern[g]);
      tick();
    end
    d_req = 0; if_req = 0;
    k = 0;
    while (busy && k < 10) begin
      tick();
      k++;
    end
    chk("t4_idle", busy, 0);
    tick();

    // 5: reset in second ACCESS cycle
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h55AA55AA;
    tick();
    chk("t5_d_gnt_c1", d_gnt, 1);
    d_req = 0;
    tick();
    chk("t5_mem_en_c2", mem_en, 1);
    #2 RST = 1'b1;
    #1;
    chk("t5_async_mem_en", mem_en, 0);
    chk("t5_async_mem_we", mem_we, 0);
    chk("t5_async_busy", busy, 0);
    tick();
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | d_done | if_done | busy;
    end
    chk("t5_no_done_after_rst", seen, 0);

    // 6: req dropped during ACCESS
    d_req = 1; d_we = 0; d_addr = 32'h304; mem_rdata = 32'h0F0F0F0F;
    tick();
    chk("t6_d_gnt_c1", d_gnt, 1);
    d_req = 0;
    tick();
    chk("t6_mem_en_c2", mem_en, 1);
    tick();
    chk("t6_d_done_c3", d_done, 1);
    chk("t6_d_rdata_c3", d_rdata, 32'h0F0F0F0F);
    chk("t6_mem_en_c3", mem_en, 0);
    tick();
    chk("t6_busy_c4", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
